// File: rtl/muldiv32_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv32_if
// Description : Execute-stage bus between the pipeline and the iterative
//               multiply/divide unit.
//               master : pipeline side (drives operands and controls)
//               slave  : muldiv32 side (drives HI/LO, busy, done)
// Ports       : SrcA/SrcB operands (SrcA is also MTHI/MTLO data),
//               start/op launch an operation, hi_we/lo_we MTHI/MTLO strobes,
//               HI/LO result registers, busy stall flag, done result pulse.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv32_if;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        start;
  logic [1:0]  op;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;

  modport master (
    output SrcA, SrcB, start, op, hi_we, lo_we,
    input  HI, LO, busy, done
  );

  modport slave (
    input  SrcA, SrcB, start, op, hi_we, lo_we,
    output HI, LO, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/muldiv32.sv
`default_nettype none
// ============================================================================
// Module      : muldiv32
// Description : Iterative 32-bit multiply/divide unit owning the HI/LO pair.
//               MULTU/MULT use a 32-step shift-add loop, DIVU/DIV a 32-step
//               restoring division; signed ops work on magnitudes and fix
//               the signs in a final cycle. Result visible 33 cycles after
//               the start edge.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous, active-high
//               bus   - muldiv32_if.slave (operands, op, start, hi_we/lo_we,
//                       HI/LO, busy, done)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv32 (
  input  logic       clk,
  input  logic       reset,
  muldiv32_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_load;
  logic        w_step;
  logic        w_fix;

  logic [5:0]  r_cnt;
  logic        r_is_div;
  logic        r_neg_q;     // negate product / quotient
  logic        r_neg_r;     // negate remainder
  logic        r_dvz;       // divisor was zero at start
  logic [31:0] r_srca;      // dividend as given, returned in HI on divide-by-zero
  logic [31:0] r_b;         // divisor magnitude
  logic [63:0] r_mcand;     // multiplicand magnitude, shifted left each step
  logic [63:0] r_prod;
  // r_quo doubles as the right-shifting multiplier during a multiply and as
  // the dividend/quotient shift register during a divide.
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;

  logic        w_signed;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        w_step = 1'b1;
        if (r_cnt == 6'd31) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath combinational helpers
  // --------------------------------------------------------------------------
  assign w_signed = bus.op[0];
  assign w_mag_a  = (w_signed && bus.SrcA[31]) ? (32'd0 - bus.SrcA) : bus.SrcA;
  assign w_mag_b  = (w_signed && bus.SrcB[31]) ? (32'd0 - bus.SrcB) : bus.SrcB;

  // Restoring-division step: the remainder is always below the divisor, so
  // the shifted value fits in 33 bits and a clear MSB of the difference
  // means the trial subtraction succeeded.
  assign w_rem_sh = {r_rem, r_quo[31]};
  assign w_diff   = w_rem_sh - {1'b0, r_b};

  assign w_prod_fix = r_neg_q ? (64'd0 - r_prod) : r_prod;
  assign w_quo_fix  = r_neg_q ? (32'd0 - r_quo)  : r_quo;
  assign w_rem_fix  = r_neg_r ? (32'd0 - r_rem)  : r_rem;

  // --------------------------------------------------------------------------
  // Datapath and HI/LO registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 6'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dvz    <= 1'b0;
      r_srca   <= 32'd0;
      r_b      <= 32'd0;
      r_mcand  <= 64'd0;
      r_prod   <= 64'd0;
      r_quo    <= 32'd0;
      r_rem    <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= w_fix;

      if (w_load) begin
        r_cnt    <= 6'd0;
        r_is_div <= bus.op[1];
        r_neg_q  <= w_signed & (bus.SrcA[31] ^ bus.SrcB[31]);
        r_neg_r  <= w_signed & bus.SrcA[31];
        r_dvz    <= (bus.SrcB == 32'd0);
        r_srca   <= bus.SrcA;
        r_b      <= w_mag_b;
        r_mcand  <= {32'd0, w_mag_a};
        r_prod   <= 64'd0;
        r_rem    <= 32'd0;
        r_quo    <= bus.op[1] ? w_mag_a : w_mag_b;
      end

      if (w_step) begin
        r_cnt <= r_cnt + 6'd1;
        if (r_is_div) begin
          if (!w_diff[32]) begin
            r_rem <= w_diff[31:0];
            r_quo <= {r_quo[30:0], 1'b1};
          end else begin
            r_rem <= w_rem_sh[31:0];
            r_quo <= {r_quo[30:0], 1'b0};
          end
        end else begin
          if (r_quo[0]) begin
            r_prod <= r_prod + r_mcand;
          end
          r_mcand <= {r_mcand[62:0], 1'b0};
          r_quo   <= {1'b0, r_quo[31:1]};
        end
      end

      if (w_fix) begin
        if (!r_is_div) begin
          r_hi <= w_prod_fix[63:32];
          r_lo <= w_prod_fix[31:0];
        end else if (r_dvz) begin
          r_hi <= r_srca;
          r_lo <= 32'hFFFF_FFFF;
        end else begin
          r_hi <= w_rem_fix;
          r_lo <= w_quo_fix;
        end
      end else if (r_state == S_IDLE) begin
        // MTHI/MTLO only while idle; a start on the same edge will later
        // overwrite these with its result.
        if (bus.hi_we) begin
          r_hi <= bus.SrcA;
        end
        if (bus.lo_we) begin
          r_lo <= bus.SrcA;
        end
      end
    end
  end

  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
`default_nettype wire

// File: doc/muldiv32.md
# muldiv32

Iterative 32-bit multiply/divide unit that sits beside `alu32` in the execute stage and owns the HI/LO register pair. The ALU returns single-cycle results. This block covers the long-latency operations (MULT, MULTU, DIV, DIVU), which it computes as 32-step shift-add and restoring-division loops. It also serves the MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. The pipeline stalls on `busy`.

## Interface
Parameters: none (width fixed at 32).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `SrcA` in 32: multiplicand or dividend; for `hi_we`/`lo_we`, the write data.
- `SrcB` in 32: multiplier or divisor.
- `start` in 1: start an operation; sampled only in IDLE.
- `op` in 2: operation select; 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `hi_we` in 1: MTHI, write `SrcA` into HI; honoured only when not busy.
- `lo_we` in 1: MTLO, write `SrcA` into LO; honoured only when not busy.
- `HI` out 32: product[63:32] or remainder.
- `LO` out 32: product[31:0] or quotient.
- `busy` out 1: operation in flight; the pipeline stalls MFHI/MFLO and the next mult/div.
- `done` out 1: one-cycle pulse when HI/LO take a new result.

## Operation
States:
- IDLE → CALC on `start`. At that edge the block latches `op`, the operand magnitudes and the result signs, and clears the step counter.
- CALC runs exactly 32 iterations, one per clock. The counter is 6 bits, counting 0..31.
- CALC → FIX after the 32nd iteration.
- FIX → IDLE unconditionally. At that edge the block applies the sign fix-up, writes HI/LO and pulses `done`.

Multiply:
- Shift-add over a 64-bit accumulator.
- Signed (MULT): magnitudes of both operands are multiplied, and the 64-bit product is negated if SrcA[31]^SrcB[31].
- MULTU: operands taken as unsigned, no fix-up.

Divide:
- Restoring division: 33-bit partial remainder and 32-bit quotient. Each step shifts left, trial-subtracts the divisor and sets the quotient bit when the difference is ≥0.
- DIV: quotient negated if the signs differ; remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0.
- Divide by zero (SrcB==0 latched at start), any op: HI=SrcA as latched, LO=0xFFFFFFFF. Latency is unchanged.

Other rules:
- `start`, `hi_we` and `lo_we` are ignored while `busy`.
- In IDLE, `hi_we`/`lo_we` write on the same edge as a `start`. The later result overwrites HI/LO.
- HI/LO hold their value between operations; they change only on `done`, `hi_we`/`lo_we` or `reset`.
- `op` and operands may change after the start edge without effect.

## Timing
- Reset values: state IDLE, HI=0, LO=0, busy=0, done=0, counter=0.
- Reset asserted mid-operation aborts immediately to these values. No result is written and no `done` pulse occurs.
- Let edge N be the edge where `start` is sampled in IDLE:
  - `busy` goes high after edge N.
  - Iterations occur at edges N+1..N+32.
  - FIX completes at edge N+33: HI/LO update, `done`=1 and `busy`=0 during the cycle after N+33.
  - Total latency is 33 cycles from the start edge to result visibility.
- `done` is registered and lasts exactly one cycle.
- `start` asserted during the `done` cycle is accepted, so operations can run back to back with no bubble.
- `busy` is registered and never glitches. HI/LO are registered outputs.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles: HI=0xFFFFFFFE, LO=0x00000001, `done` pulses once, `busy` high for exactly 33 cycles.
- MULT −3 (0xFFFFFFFD) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 7 → LO=0x0000000E, HI=0x00000002. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 5 / 0 → LO=0xFFFFFFFF, HI=5.
- Start MULTU 3×4, then pulse `start` (DIVU) and `hi_we` (SrcA=0xDEAD) at cycle 10 → both ignored; result HI=0, LO=0xC.
- `lo_we` SrcA=0x1234 in IDLE → LO=0x1234 next cycle, `done` stays 0. Back-to-back `start` in the `done` cycle → second result exactly 33 cycles after the second start.
- Assert `reset` at cycle 15 of a DIV → HI=LO=0, busy=0, done=0 immediately. No `done` afterwards. A subsequent MULTU 2×2 gives LO=4.
